// File: rtl/complete_arbiter.sv
// Complete stage: buffers ALU and MEM results in per-source FIFOs and merges them
// round-robin onto one registered completion bus toward the ROB.
module complete_arbiter #(
  parameter int DEPTH  = 4,
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              alu_valid,
  input  logic [PC_W-1:0]   alu_pc,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              mem_valid,
  input  logic              mem_from_lsq,
  input  logic [PC_W-1:0]   mem_pc,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_wr_flag,
  input  logic              mem_rd_flag,
  input  logic              rob_ready,
  output logic              alu_stall,
  output logic              mem_stall,
  output logic              comp_valid,
  output logic [PC_W-1:0]   comp_pc,
  output logic [DATA_W-1:0] comp_data,
  output logic              comp_src,
  output logic              comp_is_store,
  output logic              comp_from_lsq,
  output logic              ovf_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int AW    = PC_W + DATA_W;
  localparam int MW    = PC_W + DATA_W + 2;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - 1);

  typedef enum logic {SRC_ALU = 1'b0, SRC_MEM = 1'b1} src_e;

  logic [AW-1:0]     alu_buf_q [DEPTH];
  logic [AW-1:0]     alu_buf_d [DEPTH];
  logic [MW-1:0]     mem_buf_q [DEPTH];
  logic [MW-1:0]     mem_buf_d [DEPTH];
  logic [PTR_W-1:0]  alu_wr_q, alu_wr_d, alu_rd_q, alu_rd_d;
  logic [PTR_W-1:0]  mem_wr_q, mem_wr_d, mem_rd_q, mem_rd_d;
  logic [CNT_W-1:0]  alu_cnt_q, alu_cnt_d, mem_cnt_q, mem_cnt_d;
  src_e              last_q, last_d;
  logic              comp_valid_q, comp_valid_d;
  logic [PC_W-1:0]   comp_pc_q, comp_pc_d;
  logic [DATA_W-1:0] comp_data_q, comp_data_d;
  logic              comp_src_q, comp_src_d;
  logic              comp_is_store_q, comp_is_store_d;
  logic              comp_from_lsq_q, comp_from_lsq_d;
  logic              ovf_q, ovf_d;

  logic          alu_push, mem_push, alu_full, mem_full;
  logic          alu_wr_en, mem_wr_en, alu_pop, mem_pop;
  logic          alu_avail, mem_avail, load_out;
  logic [AW-1:0] alu_head;
  logic [MW-1:0] mem_head;

  assign alu_push  = alu_valid;
  assign mem_push  = mem_valid | mem_from_lsq;
  assign alu_full  = (alu_cnt_q == FULL_CNT);
  assign mem_full  = (mem_cnt_q == FULL_CNT);
  assign alu_wr_en = alu_push & ~alu_full & ~flush;
  assign mem_wr_en = mem_push & ~mem_full & ~flush;
  assign alu_avail = (alu_cnt_q != '0);
  assign mem_avail = (mem_cnt_q != '0);
  assign alu_head  = alu_buf_q[alu_rd_q];
  assign mem_head  = mem_buf_q[mem_rd_q];
  assign load_out  = ~comp_valid_q | rob_ready;

  always_comb begin
    alu_buf_d = alu_buf_q;
    alu_wr_d  = alu_wr_q;
    alu_rd_d  = alu_rd_q;
    if (alu_wr_en) begin
      alu_buf_d[alu_wr_q] = {alu_pc, alu_data};
      alu_wr_d            = alu_wr_q + PTR_W'(1);
    end
    if (alu_pop) alu_rd_d = alu_rd_q + PTR_W'(1);
    alu_cnt_d = alu_cnt_q + CNT_W'(alu_wr_en) - CNT_W'(alu_pop);
    if (flush) begin
      alu_wr_d  = '0;
      alu_rd_d  = '0;
      alu_cnt_d = '0;
    end
  end

  always_comb begin
    mem_buf_d = mem_buf_q;
    mem_wr_d  = mem_wr_q;
    mem_rd_d  = mem_rd_q;
    if (mem_wr_en) begin
      mem_buf_d[mem_wr_q] = {mem_pc, mem_data, mem_wr_flag, mem_from_lsq};
      mem_wr_d            = mem_wr_q + PTR_W'(1);
    end
    if (mem_pop) mem_rd_d = mem_rd_q + PTR_W'(1);
    mem_cnt_d = mem_cnt_q + CNT_W'(mem_wr_en) - CNT_W'(mem_pop);
    if (flush) begin
      mem_wr_d  = '0;
      mem_rd_d  = '0;
      mem_cnt_d = '0;
    end
  end

  // Under contention MEM wins whenever ALU was granted last, so the first tie goes to MEM.
  always_comb begin
    alu_pop         = 1'b0;
    mem_pop         = 1'b0;
    last_d          = last_q;
    comp_valid_d    = comp_valid_q;
    comp_pc_d       = comp_pc_q;
    comp_data_d     = comp_data_q;
    comp_src_d      = comp_src_q;
    comp_is_store_d = comp_is_store_q;
    comp_from_lsq_d = comp_from_lsq_q;
    if (load_out) begin
      comp_valid_d    = 1'b0;
      comp_pc_d       = '0;
      comp_data_d     = '0;
      comp_src_d      = 1'b0;
      comp_is_store_d = 1'b0;
      comp_from_lsq_d = 1'b0;
      if (mem_avail && (!alu_avail || last_q == SRC_ALU)) begin
        mem_pop         = 1'b1;
        last_d          = SRC_MEM;
        comp_valid_d    = 1'b1;
        comp_pc_d       = mem_head[MW-1 -: PC_W];
        comp_data_d     = mem_head[DATA_W+1:2];
        comp_src_d      = 1'b1;
        comp_is_store_d = mem_head[1];
        comp_from_lsq_d = mem_head[0];
      end else if (alu_avail) begin
        alu_pop      = 1'b1;
        last_d       = SRC_ALU;
        comp_valid_d = 1'b1;
        comp_pc_d    = alu_head[AW-1 -: PC_W];
        comp_data_d  = alu_head[DATA_W-1:0];
      end
    end
    if (flush) begin
      alu_pop         = 1'b0;
      mem_pop         = 1'b0;
      last_d          = SRC_ALU;
      comp_valid_d    = 1'b0;
      comp_pc_d       = '0;
      comp_data_d     = '0;
      comp_src_d      = 1'b0;
      comp_is_store_d = 1'b0;
      comp_from_lsq_d = 1'b0;
    end
    ovf_d = ovf_q | (~flush & ((alu_push & alu_full) | (mem_push & mem_full)));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        alu_buf_q[i] <= '0;
        mem_buf_q[i] <= '0;
      end
      alu_wr_q        <= '0;
      alu_rd_q        <= '0;
      alu_cnt_q       <= '0;
      mem_wr_q        <= '0;
      mem_rd_q        <= '0;
      mem_cnt_q       <= '0;
      last_q          <= SRC_ALU;
      comp_valid_q    <= 1'b0;
      comp_pc_q       <= '0;
      comp_data_q     <= '0;
      comp_src_q      <= 1'b0;
      comp_is_store_q <= 1'b0;
      comp_from_lsq_q <= 1'b0;
      ovf_q           <= 1'b0;
    end else begin
      alu_buf_q       <= alu_buf_d;
      mem_buf_q       <= mem_buf_d;
      alu_wr_q        <= alu_wr_d;
      alu_rd_q        <= alu_rd_d;
      alu_cnt_q       <= alu_cnt_d;
      mem_wr_q        <= mem_wr_d;
      mem_rd_q        <= mem_rd_d;
      mem_cnt_q       <= mem_cnt_d;
      last_q          <= last_d;
      comp_valid_q    <= comp_valid_d;
      comp_pc_q       <= comp_pc_d;
      comp_data_q     <= comp_data_d;
      comp_src_q      <= comp_src_d;
      comp_is_store_q <= comp_is_store_d;
      comp_from_lsq_q <= comp_from_lsq_d;
      ovf_q           <= ovf_d;
    end
  end

  // Stall leaves one free slot for a push already in flight when upstream reacts.
  assign alu_stall     = (alu_cnt_q >= STALL_CNT);
  assign mem_stall     = (mem_cnt_q >= STALL_CNT);
  assign comp_valid    = comp_valid_q;
  assign comp_pc       = comp_pc_q;
  assign comp_data     = comp_data_q;
  assign comp_src      = comp_src_q;
  assign comp_is_store = comp_is_store_q;
  assign comp_from_lsq = comp_from_lsq_q;
  assign ovf_err       = ovf_q;

  a_no_load_store: assert property (@(posedge clk) disable iff (!rstn)
    mem_push |-> !(mem_wr_flag && mem_rd_flag));

endmodule

// File: tb/tb_complete_arbiter.sv
// Self-checking bench for complete_arbiter: a scoreboard queue holds expected
// completions in order, and each scenario task also checks its own timing points.
module tb_complete_arbiter;

  localparam int PC_W   = 32;
  localparam int DATA_W = 32;

  typedef logic [PC_W+DATA_W+2:0] exp_t;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              flush = 1'b0;
  logic              alu_valid = 1'b0;
  logic [PC_W-1:0]   alu_pc = '0;
  logic [DATA_W-1:0] alu_data = '0;
  logic              mem_valid = 1'b0;
  logic              mem_from_lsq = 1'b0;
  logic [PC_W-1:0]   mem_pc = '0;
  logic [DATA_W-1:0] mem_data = '0;
  logic              mem_wr_flag = 1'b0;
  logic              mem_rd_flag = 1'b0;
  logic              rob_ready = 1'b0;
  logic              alu_stall, mem_stall, comp_valid, comp_src, comp_is_store, comp_from_lsq, ovf_err;
  logic [PC_W-1:0]   comp_pc;
  logic [DATA_W-1:0] comp_data;

  exp_t exp_q[$];
  exp_t got_v, want_v;
  int   checks = 0;
  int   errors = 0;

  complete_arbiter #(.DEPTH(4), .PC_W(PC_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .alu_valid(alu_valid), .alu_pc(alu_pc), .alu_data(alu_data),
    .mem_valid(mem_valid), .mem_from_lsq(mem_from_lsq), .mem_pc(mem_pc), .mem_data(mem_data),
    .mem_wr_flag(mem_wr_flag), .mem_rd_flag(mem_rd_flag), .rob_ready(rob_ready),
    .alu_stall(alu_stall), .mem_stall(mem_stall),
    .comp_valid(comp_valid), .comp_pc(comp_pc), .comp_data(comp_data), .comp_src(comp_src),
    .comp_is_store(comp_is_store), .comp_from_lsq(comp_from_lsq), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  function automatic exp_t make_exp(input logic src, input logic [PC_W-1:0] pc,
                                    input logic [DATA_W-1:0] data, input logic st, input logic lsq);
    return {src, pc, data, st, lsq};
  endfunction

  // Scoreboard: every handshake the ROB accepts must match the next expected completion.
  always @(negedge clk) begin
    if (rstn && comp_valid && rob_ready) begin
      checks++;
      got_v = {comp_src, comp_pc, comp_data, comp_is_store, comp_from_lsq};
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL completion_unexpected: got src=%0d pc=%h data=%h, required no completion",
                 comp_src, comp_pc, comp_data);
      end else begin
        want_v = exp_q.pop_front();
        if (got_v !== want_v) begin
          errors++;
          $display("[TB] FAIL completion: got {src,pc,data,st,lsq}=%h, required %h", got_v, want_v);
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    alu_valid    = 1'b0;
    mem_valid    = 1'b0;
    mem_from_lsq = 1'b0;
    mem_wr_flag  = 1'b0;
    mem_rd_flag  = 1'b0;
    flush        = 1'b0;
  endtask

  task automatic wait_drain(input int max_cycles);
    for (int i = 0; i < max_cycles && exp_q.size() != 0; i++) @(negedge clk);
    #1;
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if ({comp_valid, alu_stall, mem_stall, ovf_err, comp_src, comp_is_store, comp_from_lsq} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_flags: got %b, required 0000000",
               {comp_valid, alu_stall, mem_stall, ovf_err, comp_src, comp_is_store, comp_from_lsq});
    end
    checks++;
    if ({comp_pc, comp_data} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_bus: got pc=%h data=%h, required 0", comp_pc, comp_data);
    end
    tick;
    tick;
    rstn      = 1'b1;
    rob_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      alu_valid   = 1'b1;
      alu_pc      = 32'(32'h600 + 4 * i);
      alu_data    = 32'(i);
      mem_valid   = (i < 4);
      mem_rd_flag = (i < 4);
      mem_pc      = 32'(32'h700 + 4 * i);
      mem_data    = 32'(16 + i);
      tick;
    end
    clear_inputs();
    checks++;
    if ({comp_valid, alu_stall, mem_stall, ovf_err} !== 4'b1111) begin
      errors++;
      $display("[TB] FAIL pre_reset_traffic: got valid/astall/mstall/ovf=%b, required 1111",
               {comp_valid, alu_stall, mem_stall, ovf_err});
    end
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if ({comp_valid, alu_stall, mem_stall, ovf_err} !== 4'b0000) begin
      errors++;
      $display("[TB] FAIL async_reset: got valid/astall/mstall/ovf=%b, required 0000",
               {comp_valid, alu_stall, mem_stall, ovf_err});
    end
    exp_q.delete();
    tick;
    tick;
    rstn      = 1'b1;
    rob_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({comp_valid, alu_stall, mem_stall} !== 3'b000) begin
        errors++;
        $display("[TB] FAIL post_reset_empty: got valid/astall/mstall=%b, required 000",
                 {comp_valid, alu_stall, mem_stall});
      end
    end
  endtask

  task automatic test_single_alu;
    tick;
    rob_ready = 1'b1;
    alu_valid = 1'b1;
    alu_pc    = 32'h100;
    alu_data  = 32'h5;
    exp_q.push_back(make_exp(1'b0, 32'h100, 32'h5, 1'b0, 1'b0));
    @(posedge clk);
    #1;
    alu_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (comp_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL no_bypass: got comp_valid=%b in push cycle, required 0", comp_valid);
    end
    @(negedge clk);
    checks++;
    if ({comp_valid, comp_src, comp_pc, comp_data} !== {1'b1, 1'b0, 32'h100, 32'h5}) begin
      errors++;
      $display("[TB] FAIL single_alu: got valid=%b src=%b pc=%h data=%h, required 1 0 100 5",
               comp_valid, comp_src, comp_pc, comp_data);
    end
    wait_drain(10);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL single_alu_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_alternate;
    tick;
    rob_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(make_exp(1'b1, 32'(32'h300 + 4 * i), 32'(32'h2000 + i), 1'b0, 1'b0));
      exp_q.push_back(make_exp(1'b0, 32'(32'h200 + 4 * i), 32'(32'h1000 + i), 1'b0, 1'b0));
    end
    for (int i = 0; i < 4; i++) begin
      alu_valid   = 1'b1;
      alu_pc      = 32'(32'h200 + 4 * i);
      alu_data    = 32'(32'h1000 + i);
      mem_valid   = 1'b1;
      mem_rd_flag = 1'b1;
      mem_pc      = 32'(32'h300 + 4 * i);
      mem_data    = 32'(32'h2000 + i);
      tick;
    end
    clear_inputs();
    wait_drain(20);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL alternate_drain: got %0d pending, required 0", exp_q.size());
    end
    checks++;
    if (ovf_err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL alternate_no_drop: got ovf_err=%b, required 0", ovf_err);
    end
  endtask

  task automatic test_lsq_store;
    tick;
    rob_ready    = 1'b1;
    mem_valid    = 1'b0;
    mem_from_lsq = 1'b1;
    mem_wr_flag  = 1'b1;
    mem_pc       = 32'h44;
    mem_data     = 32'hdead_beef;
    exp_q.push_back(make_exp(1'b1, 32'h44, 32'hdead_beef, 1'b1, 1'b1));
    tick;
    clear_inputs();
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({comp_valid, comp_src, comp_is_store, comp_from_lsq, comp_pc} !== {4'b1111, 32'h44}) begin
      errors++;
      $display("[TB] FAIL lsq_store: got valid/src/st/lsq=%b pc=%h, required 1111 pc=00000044",
               {comp_valid, comp_src, comp_is_store, comp_from_lsq}, comp_pc);
    end
    wait_drain(10);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL lsq_store_drain: got %0d pending, required 0", exp_q.size());
    end
  endtask

  task automatic test_overflow;
    tick;
    rob_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1;
      alu_pc    = 32'(32'h400 + 4 * i);
      alu_data  = 32'(32'h40 + i);
      if (i < 5) exp_q.push_back(make_exp(1'b0, 32'(32'h400 + 4 * i), 32'(32'h40 + i), 1'b0, 1'b0));
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({alu_stall, ovf_err} !== {(i >= 3) ? 1'b1 : 1'b0, (i == 5) ? 1'b1 : 1'b0}) begin
        errors++;
        $display("[TB] FAIL overflow_flags[%0d]: got stall=%b ovf=%b, required stall=%b ovf=%b",
                 i, alu_stall, ovf_err, (i >= 3), (i == 5));
      end
      checks++;
      if (i == 0 ? (comp_valid !== 1'b0) : ({comp_valid, comp_pc} !== {1'b1, 32'h400})) begin
        errors++;
        $display("[TB] FAIL overflow_hold[%0d]: got valid=%b pc=%h, required %s",
                 i, comp_valid, comp_pc, (i == 0) ? "valid=0" : "valid=1 pc=00000400");
      end
    end
    alu_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if ({comp_valid, comp_pc, comp_data, ovf_err, alu_stall} !== {1'b1, 32'h400, 32'h40, 2'b11}) begin
        errors++;
        $display("[TB] FAIL stalled_stable: got valid=%b pc=%h data=%h ovf=%b stall=%b, required 1 400 40 1 1",
                 comp_valid, comp_pc, comp_data, ovf_err, alu_stall);
      end
    end
    rob_ready = 1'b1;
    wait_drain(20);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL overflow_drain: got %0d pending, required 0", exp_q.size());
    end
    @(negedge clk);
    checks++;
    if ({ovf_err, alu_stall, comp_valid} !== 3'b100) begin
      errors++;
      $display("[TB] FAIL overflow_after: got ovf/stall/valid=%b, required 100", {ovf_err, alu_stall, comp_valid});
    end
  endtask

  task automatic test_flush;
    tick;
    rob_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      alu_valid = 1'b1;
      alu_pc    = 32'(32'h500 + 4 * i);
      alu_data  = 32'(i);
      @(posedge clk);
      @(negedge clk);
    end
    checks++;
    if ({comp_valid, alu_stall} !== 2'b11) begin
      errors++;
      $display("[TB] FAIL flush_setup: got valid/stall=%b, required 11", {comp_valid, alu_stall});
    end
    flush       = 1'b1;
    alu_pc      = 32'h510;
    mem_valid   = 1'b1;
    mem_rd_flag = 1'b1;
    mem_pc      = 32'h520;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if ({comp_valid, alu_stall, mem_stall, ovf_err} !== 4'b0001) begin
      errors++;
      $display("[TB] FAIL flush: got valid/astall/mstall/ovf=%b, required 0001",
               {comp_valid, alu_stall, mem_stall, ovf_err});
    end
    clear_inputs();
    rob_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (comp_valid !== 1'b0) begin
        errors++;
        $display("[TB] FAIL flush_nothing_completes: got comp_valid=%b pc=%h, required 0", comp_valid, comp_pc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_alternate();
    test_lsq_store();
    test_overflow();
    test_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got no end of run by 100000, required earlier finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
